csr_intp_ctrl: RTL and testbench
================================

// Module: csr_intp_ctrl
// PURPOSE
//  Trap/interrupt sequencer: drives the CSR file's intp write port and redirects fetch.
//  - Takes ext/sw/timer interrupts and ecall/ebreak/mret from EXE; enables come from mstatus/mie.
//  - Writes mepc, mcause and mstatus one per cycle, then issues a one-cycle jump to mtvec (trap) or mepc (mret).
// PARAMETERS
//  VECTORED_EN  1  1: mtvec[1:0]==2'b01 vectors async traps to base+4*code; 0: always direct
//  IRQ_SYNC     1  1: 2-flop synchroniser on ext_irq; 0: use ext_irq as-is
// PORTS
//  clk             in   1   clock; single clock domain
//  rst_b           in   1   asynchronous active-low reset
//  ext_irq         in   1   machine external interrupt, level
//  sw_irq          in   1   machine software interrupt, level, synchronous to clk
//  timer_irq       in   1   machine timer interrupt, level, synchronous to clk
//  pc_vld_exe      in   1   EXE holds a valid instruction
//  pc_exe          in   32  PC of EXE instruction
//  ecall_exe       in   1   EXE instr is ecall (qualified by pc_vld_exe)
//  ebreak_exe      in   1   EXE instr is ebreak (qualified by pc_vld_exe)
//  mret_exe        in   1   EXE instr is mret (qualified by pc_vld_exe)
//  mstatus_csr     in   32  current mstatus
//  mie_csr         in   32  current mie
//  mtvec_csr       in   32  current mtvec
//  mepc_csr        in   32  current mepc
//  csr_wen_intp    out  1   CSR write strobe; wins over same-cycle EXE write to same CSR
//  csr_waddr_intp  out  12  CSR address: 0x341 mepc, 0x342 mcause, 0x300 mstatus
//  csr_wdata_intp  out  32  CSR write data
//  intp_flush      out  1   kill EXE instruction: no regfile/CSR/memory commit
//  intp_hold       out  1   stall IF/ID/EXE
//  intp_jump       out  1   one-cycle fetch redirect
//  intp_jump_addr  out  32  redirect target
// BEHAVIOUR
//  Reset: state IDLE; every output 0; capture regs 0; sync flops 0.
//  States: IDLE, W_EPC, W_CAUSE, W_STAT, W_MRET, JUMP.
//  IDLE accept (only when pc_vld_exe=1), priority high->low:
//   - mret > ecall > ebreak > ext (mstatus[3]&mie[11]&irq_s) > sw (mstatus[3]&mie[3]) > timer (mstatus[3]&mie[7]).
//   - Accept cycle: intp_flush=1 and intp_hold=1 combinationally.
//   - Trap captures pc_exe->epc_q, mstatus_csr->stat_q, cause->cause_q.
//   - Causes: ecall 0x0000000B, ebreak 0x00000003, ext 0x8000000B, sw 0x80000003, timer 0x80000007.
//   - Next state: trap->W_EPC; mret->W_MRET.
//  Trap path:
//   - W_EPC: wen=1, addr 0x341, data epc_q.
//   - W_CAUSE: wen=1, addr 0x342, data cause_q.
//   - W_STAT: wen=1, addr 0x300, data stat_q with [7]=stat_q[3], [3]=0, [12:11]=2'b11; other bits unchanged.
//  mret path:
//   - W_MRET: wen=1, addr 0x300, data mstatus_csr with [3]=mstatus_csr[7], [7]=1, [12:11]=2'b11.
//  JUMP: intp_jump=1; state returns to IDLE next cycle.
//   - Trap target: mtvec_csr[1:0]==01 && VECTORED_EN && cause_q[31] -> {mtvec[31:2],2'b00}+(cause_q[4:0]<<2);
//     otherwise {mtvec[31:2],2'b00}. Sampled from the mtvec_csr input in the JUMP cycle.
//   - mret target: {mepc_csr[31:2],2'b00}, sampled in the JUMP cycle, so the W_EPC write is visible.
//  intp_hold=1 from the accept cycle through JUMP inclusive; 0 in IDLE otherwise.
//  Latency: trap = accept + 4 cycles to jump; mret = accept + 2 cycles.
//  Events seen while not in IDLE are ignored; levels re-evaluate in IDLE. A trap clears MIE, so async irqs stay masked until mret.
//  pc_vld_exe=0 in IDLE: nothing accepted, pending irqs wait.
//  Reset mid-sequence: immediate IDLE, no further writes; partial CSR writes stay as written.
//  Address/target arithmetic is 32-bit, wraps modulo 2^32, no overflow flag.
// STRUCTURE
//  Shared package: CSR address constants (0x300/0x304/0x305/0x341/0x342), mcause codes,
//   mstatus bit indices (MIE=3, MPIE=7, MPP=12:11), state encoding.
//  One sub-module: irq_sync2 (2-flop level synchroniser, async active-low reset), instantiated on ext_irq when IRQ_SYNC=1.
//  Everything else flat: FSM, capture regs, write-mux, target calc.
// TESTING
//  1. ecall at pc_exe=0x80000100, mtvec=0x80000000:
//     wen seq 0x341/0x80000100, 0x342/0x0000000B, 0x300 with MPIE=old MIE, MIE=0;
//     jump to 0x80000000 at accept+4; hold high for 5 cycles.
//  2. mstatus=0x8, mie=0x800, ext_irq=1, mtvec=0x80000001 (vectored):
//     mcause 0x8000000B, jump 0x8000002C. Rerun with VECTORED_EN=0 -> jump 0x80000000.
//  3. mret with mstatus=0x80, mepc=0x80000204:
//     one write 0x300 with MIE=1, MPIE=1; jump 0x80000204 at accept+2.
//  4. ext+sw+timer all pending and enabled -> ext taken first (mcause 0x8000000B).
//     mstatus[3]=0 -> none taken. pc_vld_exe=0 -> waits.
//  5. Assert rst_b low during W_CAUSE -> all outputs 0 at once; after release IDLE, no jump issued.
//  6. Raise timer_irq during W_EPC of an ecall trap -> ignored; after JUMP it stays masked (MIE=0) until mret.

Source files
------------

// File: rtl/csr_intp_ctrl_pkg.sv
// Shared constants, state encoding and mstatus update helpers for the
// trap/interrupt sequencer.
package csr_intp_ctrl_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // mcause values
  localparam logic [31:0] CAUSE_ECALL  = 32'h0000_000B;
  localparam logic [31:0] CAUSE_EBREAK = 32'h0000_0003;
  localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;
  localparam logic [31:0] CAUSE_SW     = 32'h8000_0003;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;

  // mstatus / mie bit positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIE_MSIE       = 3;
  localparam int MIE_MTIE       = 7;
  localparam int MIE_MEIE       = 11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_W_EPC   = 3'd1,
    ST_W_CAUSE = 3'd2,
    ST_W_STAT  = 3'd3,
    ST_W_MRET  = 3'd4,
    ST_JUMP    = 3'd5
  } state_e;

  // Trap entry: stash MIE into MPIE, disable interrupts, MPP = machine.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] i_stat);
    logic [31:0] r;
    r = i_stat;
    r[MSTATUS_MPIE] = i_stat[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE, set MPIE, MPP = machine.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] i_stat);
    logic [31:0] r;
    r = i_stat;
    r[MSTATUS_MIE]  = i_stat[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/irq_sync2.sv
// Two-flop level synchroniser for an asynchronous interrupt line.
module irq_sync2 (
  input  logic clk,
  input  logic rst_b,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the level through two flops to resolve metastability
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/csr_intp_ctrl.sv
// Trap/interrupt sequencer: on an accepted trap writes mepc, mcause and
// mstatus one per cycle, then redirects fetch to mtvec; on mret rewrites
// mstatus and redirects fetch to mepc.
module csr_intp_ctrl
  import csr_intp_ctrl_pkg::*;
#(
  parameter bit VECTORED_EN = 1'b1,
  parameter bit IRQ_SYNC    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        ext_irq,
  input  logic        sw_irq,
  input  logic        timer_irq,
  input  logic        pc_vld_exe,
  input  logic [31:0] pc_exe,
  input  logic        ecall_exe,
  input  logic        ebreak_exe,
  input  logic        mret_exe,
  input  logic [31:0] mstatus_csr,
  input  logic [31:0] mie_csr,
  input  logic [31:0] mtvec_csr,
  input  logic [31:0] mepc_csr,
  output logic        csr_wen_intp,
  output logic [11:0] csr_waddr_intp,
  output logic [31:0] csr_wdata_intp,
  output logic        intp_flush,
  output logic        intp_hold,
  output logic        intp_jump,
  output logic [31:0] intp_jump_addr
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_epc_q;
  logic [31:0] r_stat_q;
  logic [31:0] r_cause_q;
  logic        r_is_mret;

  logic        w_ext_irq_s;
  logic        w_ext_en;
  logic        w_sw_en;
  logic        w_tmr_en;
  logic        w_accept;
  logic [31:0] w_cause;
  logic [31:0] w_mtvec_base;
  logic [31:0] w_trap_tgt;
  logic        w_unused;

  if (IRQ_SYNC) begin : g_ext_sync
    irq_sync2 u_ext_sync (
      .clk   (clk),
      .rst_b (rst_b),
      .i_d   (ext_irq),
      .o_q   (w_ext_irq_s)
    );
  end else begin : g_ext_raw
    assign w_ext_irq_s = ext_irq;
  end

  assign w_ext_en = mstatus_csr[MSTATUS_MIE] & mie_csr[MIE_MEIE] & w_ext_irq_s;
  assign w_sw_en  = mstatus_csr[MSTATUS_MIE] & mie_csr[MIE_MSIE] & sw_irq;
  assign w_tmr_en = mstatus_csr[MSTATUS_MIE] & mie_csr[MIE_MTIE] & timer_irq;

  // Gated by rst_b so flush/hold stay low while reset is held.
  assign w_accept = rst_b & pc_vld_exe &
                    (mret_exe | ecall_exe | ebreak_exe | w_ext_en | w_sw_en | w_tmr_en);

  // Trap cause in priority order (mret is handled separately, above all of these)
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
    w_cause = CAUSE_TIMER;
    if (ecall_exe)       w_cause = CAUSE_ECALL;
    else if (ebreak_exe) w_cause = CAUSE_EBREAK;
    else if (w_ext_en)   w_cause = CAUSE_EXT;
    else if (w_sw_en)    w_cause = CAUSE_SW;
  end

  assign w_mtvec_base = {mtvec_csr[31:2], 2'b00};
  assign w_trap_tgt   = (VECTORED_EN && (mtvec_csr[1:0] == 2'b01) && r_cause_q[31])
                      ? w_mtvec_base + {25'd0, r_cause_q[4:0], 2'b00}
                      : w_mtvec_base;

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_b) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_state_nxt = mret_exe ? ST_W_MRET : ST_W_EPC;
      ST_W_EPC:   w_state_nxt = ST_W_CAUSE;
      ST_W_CAUSE: w_state_nxt = ST_W_STAT;
      ST_W_STAT:  w_state_nxt = ST_JUMP;
      ST_W_MRET:  w_state_nxt = ST_JUMP;
      ST_JUMP:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture trap context in the accept cycle
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_epc_q   <= '0;
      r_stat_q  <= '0;
      r_cause_q <= '0;
      r_is_mret <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_accept) begin
      r_is_mret <= mret_exe;
      if (!mret_exe) begin
        r_epc_q   <= pc_exe;
        r_stat_q  <= mstatus_csr;
        r_cause_q <= w_cause;
      end
    end
  end

  // Output decode: CSR write mux, pipeline control and fetch redirect
  always_comb begin
    csr_wen_intp   = 1'b0;
    csr_waddr_intp = '0;
    csr_wdata_intp = '0;
    intp_flush     = 1'b0;
    intp_hold      = 1'b0;
    intp_jump      = 1'b0;
    intp_jump_addr = '0;
    case (r_state)
      ST_IDLE: begin
        intp_flush = w_accept;
        intp_hold  = w_accept;
      end
      ST_W_EPC: begin
        intp_hold      = 1'b1;
        csr_wen_intp   = 1'b1;
        csr_waddr_intp = CSR_MEPC;
        csr_wdata_intp = r_epc_q;
      end
      ST_W_CAUSE: begin
        intp_hold      = 1'b1;
        csr_wen_intp   = 1'b1;
        csr_waddr_intp = CSR_MCAUSE;
        csr_wdata_intp = r_cause_q;
      end
      ST_W_STAT: begin
        intp_hold      = 1'b1;
        csr_wen_intp   = 1'b1;
        csr_waddr_intp = CSR_MSTATUS;
        csr_wdata_intp = trap_mstatus(r_stat_q);
      end
      ST_W_MRET: begin
        intp_hold      = 1'b1;
        csr_wen_intp   = 1'b1;
        csr_waddr_intp = CSR_MSTATUS;
        csr_wdata_intp = mret_mstatus(mstatus_csr);
      end
      ST_JUMP: begin
        intp_hold      = 1'b1;
        intp_jump      = 1'b1;
        intp_jump_addr = r_is_mret ? {mepc_csr[31:2], 2'b00} : w_trap_tgt;
      end
      default: ;
    endcase
  end

  // Only the enable bits of mie and the word-aligned part of mepc matter here.
  assign w_unused = ^{mie_csr[31:12], mie_csr[10:8], mie_csr[6:4], mie_csr[2:0], mepc_csr[1:0]};

endmodule

// File: tb/tb_csr_intp_ctrl.sv
// Self-checking bench for csr_intp_ctrl: directed scenarios plus randomized
// trials against a behavioural model of trap/mret sequencing. The bench also
// plays the CSR file, applying the model's expected writes to its registers.
module tb_csr_intp_ctrl;

  logic        clk        = 1'b0;
  logic        rst_b      = 1'b0;
  logic        ext_irq    = 1'b0;
  logic        sw_irq     = 1'b0;
  logic        timer_irq  = 1'b0;
  logic        pc_vld_exe = 1'b0;
  logic [31:0] pc_exe     = '0;
  logic        ecall_exe  = 1'b0;
  logic        ebreak_exe = 1'b0;
  logic        mret_exe   = 1'b0;
  logic [31:0] tb_mstatus = '0;
  logic [31:0] tb_mie     = '0;
  logic [31:0] tb_mtvec   = '0;
  logic [31:0] tb_mepc    = '0;

  logic        csr_wen_intp;
  logic [11:0] csr_waddr_intp;
  logic [31:0] csr_wdata_intp;
  logic        intp_flush;
  logic        intp_hold;
  logic        intp_jump;
  logic [31:0] intp_jump_addr;

  // Direct-mode instance, only its redirect outputs are compared
  logic        d_unused_wen;
  logic [11:0] d_unused_waddr;
  logic [31:0] d_unused_wdata;
  logic        d_unused_flush;
  logic        d_unused_hold;
  logic        d_jump;
  logic [31:0] d_jump_addr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wen;
    logic [11:0] addr;
    logic [31:0] data;
    logic        jump;
    logic [31:0] jaddr;
    logic [31:0] jaddr_d;
  } step_t;

  always #5 clk = ~clk;

  csr_intp_ctrl #(.VECTORED_EN(1'b1), .IRQ_SYNC(1'b1)) u_dut (
    .clk(clk), .rst_b(rst_b), .ext_irq(ext_irq), .sw_irq(sw_irq), .timer_irq(timer_irq),
    .pc_vld_exe(pc_vld_exe), .pc_exe(pc_exe), .ecall_exe(ecall_exe), .ebreak_exe(ebreak_exe),
    .mret_exe(mret_exe), .mstatus_csr(tb_mstatus), .mie_csr(tb_mie), .mtvec_csr(tb_mtvec),
    .mepc_csr(tb_mepc), .csr_wen_intp(csr_wen_intp), .csr_waddr_intp(csr_waddr_intp),
    .csr_wdata_intp(csr_wdata_intp), .intp_flush(intp_flush), .intp_hold(intp_hold),
    .intp_jump(intp_jump), .intp_jump_addr(intp_jump_addr)
  );

  csr_intp_ctrl #(.VECTORED_EN(1'b0), .IRQ_SYNC(1'b1)) u_dut_d (
    .clk(clk), .rst_b(rst_b), .ext_irq(ext_irq), .sw_irq(sw_irq), .timer_irq(timer_irq),
    .pc_vld_exe(pc_vld_exe), .pc_exe(pc_exe), .ecall_exe(ecall_exe), .ebreak_exe(ebreak_exe),
    .mret_exe(mret_exe), .mstatus_csr(tb_mstatus), .mie_csr(tb_mie), .mtvec_csr(tb_mtvec),
    .mepc_csr(tb_mepc), .csr_wen_intp(d_unused_wen), .csr_waddr_intp(d_unused_waddr),
    .csr_wdata_intp(d_unused_wdata), .intp_flush(d_unused_flush), .intp_hold(d_unused_hold),
    .intp_jump(d_jump), .intp_jump_addr(d_jump_addr)
  );

  // Model rules for mstatus on trap entry and on mret
  function automatic logic [31:0] model_trap_stat(input logic [31:0] s);
    return (s & ~32'h0000_1888) | (s[3] ? 32'h80 : 32'h0) | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] model_mret_stat(input logic [31:0] s);
    return (s & ~32'h0000_1808) | (s[7] ? 32'h8 : 32'h0) | 32'h0000_1880;
  endfunction

  // Cycles with no valid EXE instruction: nothing may start
  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pc_vld_exe = 1'b0;
      #1;
      checks++;
      if ({intp_flush, intp_hold, csr_wen_intp, intp_jump} !== 4'b0000) begin
        errors++;
        $display("FAIL %s idle: flush/hold/wen/jump got %b exp 0000", tag,
                 {intp_flush, intp_hold, csr_wen_intp, intp_jump});
      end
    end
  endtask

  // Present the current inputs with pc_vld_exe=1 for one cycle and follow
  // whatever sequence the model predicts, cycle by cycle.
  task automatic accept_and_check(input string tag, input bit raise_timer);
    int          w;
    logic        gie;
    logic        exp_acc;
    logic [31:0] cause;
    logic [31:0] base;
    logic [31:0] tgt;
    logic [31:0] pc_acc;
    step_t       q[$];

    gie = tb_mstatus[3];
    if (mret_exe)                          w = 1;
    else if (ecall_exe)                    w = 2;
    else if (ebreak_exe)                   w = 3;
    else if (gie && tb_mie[11] && ext_irq) w = 4;
    else if (gie && tb_mie[3] && sw_irq)   w = 5;
    else if (gie && tb_mie[7] && timer_irq) w = 6;
    else                                   w = 0;
    pc_acc  = pc_exe;
    exp_acc = (w != 0);

    @(negedge clk);
    pc_vld_exe = 1'b1;
    #1;
    checks++;
    if ({intp_flush, intp_hold, csr_wen_intp, intp_jump} !== {exp_acc, exp_acc, 2'b00}) begin
      errors++;
      $display("FAIL %s accept: flush/hold/wen/jump got %b exp %b", tag,
               {intp_flush, intp_hold, csr_wen_intp, intp_jump}, {exp_acc, exp_acc, 2'b00});
    end

    if (w == 1) begin
      q.push_back('{wen: 1'b1, addr: 12'h300, data: model_mret_stat(tb_mstatus),
                    jump: 1'b0, jaddr: 32'h0, jaddr_d: 32'h0});
      q.push_back('{wen: 1'b0, addr: 12'h000, data: 32'h0, jump: 1'b1,
                    jaddr: tb_mepc & 32'hFFFF_FFFC, jaddr_d: tb_mepc & 32'hFFFF_FFFC});
    end else if (w != 0) begin
      case (w)
        2:       cause = 32'h0000_000B;
        3:       cause = 32'h0000_0003;
        4:       cause = 32'h8000_000B;
        5:       cause = 32'h8000_0003;
        default: cause = 32'h8000_0007;
      endcase
      base = tb_mtvec & 32'hFFFF_FFFC;
      tgt  = (tb_mtvec[1:0] == 2'b01 && cause[31]) ? base + 32'd4 * (cause & 32'h1F) : base;
      q.push_back('{wen: 1'b1, addr: 12'h341, data: pc_acc, jump: 1'b0, jaddr: 32'h0, jaddr_d: 32'h0});
      q.push_back('{wen: 1'b1, addr: 12'h342, data: cause, jump: 1'b0, jaddr: 32'h0, jaddr_d: 32'h0});
      q.push_back('{wen: 1'b1, addr: 12'h300, data: model_trap_stat(tb_mstatus),
                    jump: 1'b0, jaddr: 32'h0, jaddr_d: 32'h0});
      q.push_back('{wen: 1'b0, addr: 12'h000, data: 32'h0, jump: 1'b1, jaddr: tgt, jaddr_d: base});
    end

    foreach (q[i]) begin
      @(negedge clk);
      // Anything EXE presents while busy must be ignored
      pc_vld_exe = ($urandom_range(0, 1) == 1);
      ecall_exe  = ($urandom_range(0, 1) == 1);
      ebreak_exe = ($urandom_range(0, 1) == 1);
      mret_exe   = ($urandom_range(0, 1) == 1);
      pc_exe     = $urandom;
      if (raise_timer && i == 0) timer_irq = 1'b1;
      #1;
      checks++;
      if ({intp_flush, intp_hold, csr_wen_intp, intp_jump} !== {1'b0, 1'b1, q[i].wen, q[i].jump}) begin
        errors++;
        $display("FAIL %s step%0d ctrl: flush/hold/wen/jump got %b exp %b", tag, i,
                 {intp_flush, intp_hold, csr_wen_intp, intp_jump}, {1'b0, 1'b1, q[i].wen, q[i].jump});
      end
      if (q[i].wen) begin
        checks++;
        if ({csr_waddr_intp, csr_wdata_intp} !== {q[i].addr, q[i].data}) begin
          errors++;
          $display("FAIL %s step%0d write: got %h/%h exp %h/%h", tag, i,
                   csr_waddr_intp, csr_wdata_intp, q[i].addr, q[i].data);
        end
        if (q[i].addr == 12'h300) tb_mstatus = q[i].data;
        if (q[i].addr == 12'h341) tb_mepc    = q[i].data;
      end
      if (q[i].jump) begin
        checks++;
        if (intp_jump_addr !== q[i].jaddr) begin
          errors++;
          $display("FAIL %s jump_addr: got %h exp %h", tag, intp_jump_addr, q[i].jaddr);
        end
        checks++;
        if ({d_jump, d_jump_addr} !== {1'b1, q[i].jaddr_d}) begin
          errors++;
          $display("FAIL %s direct jump: got %b/%h exp 1/%h", tag, d_jump, d_jump_addr, q[i].jaddr_d);
        end
      end
    end

    @(negedge clk);
    pc_vld_exe = 1'b0;
    ecall_exe  = 1'b0;
    ebreak_exe = 1'b0;
    mret_exe   = 1'b0;
    #1;
    checks++;
    if ({intp_flush, intp_hold, csr_wen_intp, intp_jump} !== 4'b0000) begin
      errors++;
      $display("FAIL %s after: flush/hold/wen/jump got %b exp 0000", tag,
               {intp_flush, intp_hold, csr_wen_intp, intp_jump});
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({csr_wen_intp, csr_waddr_intp, csr_wdata_intp, intp_flush, intp_hold, intp_jump, intp_jump_addr} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got nonzero wen=%b addr=%h data=%h jump=%b jaddr=%h exp all 0",
               csr_wen_intp, csr_waddr_intp, csr_wdata_intp, intp_jump, intp_jump_addr);
    end
    @(negedge clk);
    rst_b = 1'b1;
    idle(2, "post_reset");
  endtask

  task automatic test_ecall();
    tb_mstatus = 32'h8;
    tb_mtvec   = 32'h8000_0000;
    pc_exe     = 32'h8000_0100;
    ecall_exe  = 1'b1;
    accept_and_check("ecall", 1'b0);
  endtask

  task automatic test_vectored_ext();
    tb_mstatus = 32'h8;
    tb_mie     = 32'h800;
    tb_mtvec   = 32'h8000_0001;
    pc_exe     = 32'h8000_0040;
    ext_irq    = 1'b1;
    idle(3, "ext_settle");
    accept_and_check("ext_vectored", 1'b0);
    ext_irq = 1'b0;
    idle(3, "ext_drop");
  endtask

  task automatic test_mret();
    tb_mstatus = 32'h80;
    tb_mepc    = 32'h8000_0204;
    mret_exe   = 1'b1;
    accept_and_check("mret", 1'b0);
  endtask

  task automatic test_priority();
    tb_mie    = 32'h888;
    tb_mtvec  = 32'h8000_0001;
    ext_irq   = 1'b1;
    sw_irq    = 1'b1;
    timer_irq = 1'b1;
    tb_mstatus = 32'h0;
    idle(3, "masked_settle");
    accept_and_check("all_masked", 1'b0);
    tb_mstatus = 32'h8;
    idle(4, "pending_no_vld");
    accept_and_check("prio_ext", 1'b0);
    {ext_irq, sw_irq, timer_irq} = 3'b000;
    idle(3, "prio_clear");
  endtask

  task automatic test_reset_mid();
    tb_mstatus = 32'h8;
    pc_exe     = 32'h1234_5678;
    ecall_exe  = 1'b1;
    @(negedge clk);
    pc_vld_exe = 1'b1;
    @(negedge clk);
    pc_vld_exe = 1'b0;
    ecall_exe  = 1'b0;
    tb_mepc    = 32'h1234_5678;
    @(negedge clk);
    #1;
    checks++;
    if ({csr_wen_intp, csr_waddr_intp} !== {1'b1, 12'h342}) begin
      errors++;
      $display("FAIL reset_mid W_CAUSE: got %b/%h exp 1/342", csr_wen_intp, csr_waddr_intp);
    end
    rst_b = 1'b0;
    #1;
    checks++;
    if ({csr_wen_intp, csr_waddr_intp, csr_wdata_intp, intp_flush, intp_hold, intp_jump, intp_jump_addr} !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs: wen=%b addr=%h hold=%b jump=%b exp all 0",
               csr_wen_intp, csr_waddr_intp, intp_hold, intp_jump);
    end
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    idle(6, "reset_mid_after");
  endtask

  task automatic test_timer_masked();
    tb_mstatus = 32'h8;
    tb_mie     = 32'h80;
    tb_mtvec   = 32'h8000_0001;
    timer_irq  = 1'b0;
    pc_exe     = 32'h8000_0300;
    ecall_exe  = 1'b1;
    accept_and_check("ecall_timer_late", 1'b1);
    accept_and_check("timer_masked", 1'b0);
    mret_exe = 1'b1;
    accept_and_check("mret_unmask", 1'b0);
    pc_exe = 32'h8000_0400;
    accept_and_check("timer_taken", 1'b0);
    timer_irq = 1'b0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      tb_mstatus = $urandom;
      tb_mie     = $urandom;
      tb_mtvec   = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 1) == 1) ? 32'h1 : 32'h2);
      tb_mepc    = $urandom;
      pc_exe     = $urandom;
      ext_irq    = ($urandom_range(0, 1) == 1);
      sw_irq     = ($urandom_range(0, 1) == 1);
      timer_irq  = ($urandom_range(0, 1) == 1);
      mret_exe   = ($urandom_range(0, 5) == 0);
      ecall_exe  = ($urandom_range(0, 4) == 0);
      ebreak_exe = ($urandom_range(0, 4) == 0);
      idle(3, "rand_settle");
      accept_and_check($sformatf("rand%0d", t), 1'b0);
    end
    {ext_irq, sw_irq, timer_irq} = 3'b000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ecall();
    test_vectored_ext();
    test_mret();
    test_priority();
    test_reset_mid();
    test_timer_masked();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
